mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_if.sv | 16 +
 rtl/mult_div_unit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mult_div_unit_if.sv
// Request/response bundle of the sequential 32-bit signed multiply/divide unit.
// The master drives the request and observes status and result; the slave is the unit.
interface mult_div_unit_if;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input busy, done, div_zero, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiplier (radix-2 Booth) and restoring divider.
// The two share one 33-bit accumulator and one 32-bit shift register.
module mult_div_unit (
    input  logic             clk,
    input  logic             reset,
    mult_div_unit_if.slave   bus
);
    typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic        op_q;
    logic        dz_q;
    logic        neg_a_q;
    logic        neg_b_q;
    logic [31:0] m_q;
    logic [32:0] acc_q;
    logic [31:0] low_q;
    logic        qm1_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [32:0] booth_sum;
    logic [32:0] rem_sh;
    logic [32:0] trial;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                if (!bus.op)              state_d = S_MULT;
                else if (bus.b == 32'd0)  state_d = S_DONE;
                else                      state_d = S_DIV;
            end
            S_MULT:  if (cnt_q == 5'd31) state_d = S_FIX;
            S_DIV:   if (cnt_q == 5'd31) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state_q == S_MULT) || (state_q == S_DIV) || (state_q == S_FIX);
        bus.done     = (state_q == S_DONE);
        bus.div_zero = (state_q == S_DONE) && dz_q;
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;

    // Booth step: multiplicand sign-extended to 33 bits so -2^31 * -2^31 cannot overflow
    always_comb begin
        case ({low_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + {m_q[31], m_q};
            2'b10:   booth_sum = acc_q - {m_q[31], m_q};
            default: booth_sum = acc_q;
        endcase
    end

    // Divisor magnitude is unsigned here; 0x80000000 is a valid magnitude
    assign rem_sh = {acc_q[31:0], low_q[31]};
    assign trial  = rem_sh - {1'b0, m_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= 5'd0;
            op_q    <= 1'b0;
            dz_q    <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            m_q     <= 32'd0;
            acc_q   <= 33'd0;
            low_q   <= 32'd0;
            qm1_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.start) begin
                    cnt_q   <= 5'd0;
                    op_q    <= bus.op;
                    dz_q    <= bus.op && (bus.b == 32'd0);
                    neg_a_q <= bus.a[31];
                    neg_b_q <= bus.b[31];
                    acc_q   <= 33'd0;
                    qm1_q   <= 1'b0;
                    if (!bus.op) begin
                        m_q   <= bus.a;
                        low_q <= bus.b;
                    end else begin
                        m_q   <= bus.b[31] ? (32'd0 - bus.b) : bus.b;
                        low_q <= bus.a[31] ? (32'd0 - bus.a) : bus.a;
                    end
                end
                S_MULT: begin
                    cnt_q <= cnt_q + 5'd1;
                    acc_q <= {booth_sum[32], booth_sum[32:1]};
                    low_q <= {booth_sum[0], low_q[31:1]};
                    qm1_q <= low_q[0];
                end
                S_DIV: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (!trial[32]) begin
                        acc_q <= trial;
                        low_q <= {low_q[30:0], 1'b1};
                    end else begin
                        acc_q <= rem_sh;
                        low_q <= {low_q[30:0], 1'b0};
                    end
                end
                S_FIX: begin
                    if (!op_q) begin
                        hi_q <= acc_q[31:0];
                        lo_q <= low_q;
                    end else begin
                        hi_q <= neg_a_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
                        lo_q <= (neg_a_q ^ neg_b_q) ? (32'd0 - low_q) : low_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
